// File: rtl/regfile_mp.sv
// Multi-port register file: two write ports, NUM_RD combinational read ports with
// write-to-read bypass, optional hardwired zero register and a clear sweep after reset.
module regfile_mp #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned DEPTH    = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned NUM_RD   = 2,
    parameter int unsigned ZERO_REG = 1
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       clr_i,
    output logic                       busy_o,
    input  logic [NUM_RD*ADDR_W-1:0]   rd_addr_i,
    output logic [NUM_RD*DATA_W-1:0]   rd_data_o,
    input  logic                       we0_i,
    input  logic [ADDR_W-1:0]          wa0_i,
    input  logic [DATA_W-1:0]          wd0_i,
    input  logic                       we1_i,
    input  logic [ADDR_W-1:0]          wa1_i,
    input  logic [DATA_W-1:0]          wd1_i
);

    typedef enum logic {CLEAR, READY} state_e;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);
    localparam logic              ZERO_EN  = (ZERO_REG != 0);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   idx_q, idx_d;
    logic [DATA_W-1:0]   mem_q [DEPTH];

    logic in_clear;
    logic wr0_ok, wr1_ok;

    assign in_clear = (state_q == CLEAR);
    assign busy_o   = in_clear;
    assign wr0_ok   = !in_clear && we0_i && !(ZERO_EN && (wa0_i == '0));
    assign wr1_ok   = !in_clear && we1_i && !(ZERO_EN && (wa1_i == '0));

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= CLEAR;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            CLEAR: begin
                idx_d = idx_q + 1'b1;
                if (idx_q == LAST_IDX) begin
                    state_d = READY;
                    idx_d   = '0;
                end
            end
            READY: begin
                if (clr_i) begin
                    state_d = CLEAR;
                    idx_d   = '0;
                end
            end
            default: begin
                state_d = CLEAR;
                idx_d   = '0;
            end
        endcase
    end

    // Array has no reset; gating on rst_i keeps an edge seen during reset from writing.
    // Port 1 is assigned last so it wins on an address collision.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            if (in_clear) begin
                mem_q[idx_q] <= '0;
            end else begin
                if (wr0_ok) mem_q[wa0_i] <= wd0_i;
                if (wr1_ok) mem_q[wa1_i] <= wd1_i;
            end
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        logic [DATA_W-1:0] rdat;

        assign ra = rd_addr_i[k*ADDR_W +: ADDR_W];

        // wr*_ok already excludes CLEAR and zero-register writes, so bypass inherits both.
        always_comb begin
            rdat = mem_q[ra];
            if (wr0_ok && (wa0_i == ra)) rdat = wd0_i;
            if (wr1_ok && (wa1_i == ra)) rdat = wd1_i;
            if (in_clear || (ZERO_EN && (ra == '0))) rdat = '0;
        end

        assign rd_data_o[k*DATA_W +: DATA_W] = rdat;
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: one instance with the zero register enabled, one
// without; expected values are queued as stimulus is driven and drained each cycle.
module tb_regfile_mp;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        clr_i;
    logic [9:0]  rd_addr_i;
    logic        we0_i, we1_i;
    logic [4:0]  wa0_i, wa1_i;
    logic [31:0] wd0_i, wd1_i;

    logic        busy_a, busy_b;
    logic [63:0] rd_a, rd_b;

    always #5 clk_i = ~clk_i;

    regfile_mp #(.DATA_W(32), .DEPTH(32), .ADDR_W(5), .NUM_RD(2), .ZERO_REG(1)) dut_a (
        .clk_i(clk_i), .rst_i(rst_i), .clr_i(clr_i), .busy_o(busy_a),
        .rd_addr_i(rd_addr_i), .rd_data_o(rd_a),
        .we0_i(we0_i), .wa0_i(wa0_i), .wd0_i(wd0_i),
        .we1_i(we1_i), .wa1_i(wa1_i), .wd1_i(wd1_i)
    );

    regfile_mp #(.DATA_W(32), .DEPTH(32), .ADDR_W(5), .NUM_RD(2), .ZERO_REG(0)) dut_b (
        .clk_i(clk_i), .rst_i(rst_i), .clr_i(clr_i), .busy_o(busy_b),
        .rd_addr_i(rd_addr_i), .rd_data_o(rd_b),
        .we0_i(we0_i), .wa0_i(wa0_i), .wd0_i(wd0_i),
        .we1_i(we1_i), .wa1_i(wa1_i), .wd1_i(wd1_i)
    );

    typedef struct {
        string       tag;
        int          sel;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    localparam int BUSY_A = 0, RD0_A = 1, RD1_A = 2, BUSY_B = 3, RD0_B = 4, RD1_B = 5;

    function automatic logic [31:0] observe(input int sel);
        case (sel)
            BUSY_A:  return {31'b0, busy_a};
            RD0_A:   return rd_a[31:0];
            RD1_A:   return rd_a[63:32];
            BUSY_B:  return {31'b0, busy_b};
            RD0_B:   return rd_b[31:0];
            default: return rd_b[63:32];
        endcase
    endfunction

    task automatic ex(input string tag, input int sel, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic nx();
        @(negedge clk_i);
    endtask

    task automatic drv(input logic w0, input logic [4:0] a0, input logic [31:0] d0,
                       input logic w1, input logic [4:0] a1, input logic [31:0] d1,
                       input logic [4:0] r0, input logic [4:0] r1, input logic c);
        we0_i = w0; wa0_i = a0; wd0_i = d0;
        we1_i = w1; wa1_i = a1; wd1_i = d1;
        rd_addr_i = {r1, r0};
        clr_i = c;
    endtask

    task automatic chk();
        exp_t        e;
        logic [31:0] obs;
        #2;
        while (sb.size() > 0) begin
            e   = sb.pop_front();
            obs = observe(e.sel);
            checks++;
            assert (obs === e.val) else begin
                errors++;
                $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic idle(input logic [4:0] r0, input logic [4:0] r1);
        drv(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, r0, r1, 1'b0);
    endtask

    initial begin
        rst_i = 1'b0;
        idle(5'd3, 5'd3);
        repeat (3) nx();
        ex("reset_busy", BUSY_A, 32'd1);
        ex("reset_rd0", RD0_A, 32'd0);
        ex("reset_rd1", RD1_A, 32'd0);
        ex("reset_busy_b", BUSY_B, 32'd1);
        chk();

        // Reset release with a write held on addr 3; writes during the sweep are ignored.
        for (int i = 0; i < 41; i++) begin
            nx();
            if (i == 0) rst_i = 1'b1;
            drv(i != 32, 5'd3, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0, 5'd3, 5'd3, 1'b0);
            if (i < 32) begin
                ex("sweep_busy", BUSY_A, 32'd1);
                ex("sweep_rd0", RD0_A, 32'd0);
                ex("sweep_rd1", RD1_A, 32'd0);
            end else if (i == 32) begin
                ex("sweep_done_busy", BUSY_A, 32'd0);
                ex("clear_ignores_wr", RD0_A, 32'd0);
                ex("sweep_done_busy_b", BUSY_B, 32'd0);
            end else begin
                ex("ready_busy", BUSY_A, 32'd0);
                ex("ready_wr3_rd0", RD0_A, 32'hDEADBEEF);
                ex("ready_wr3_rd1", RD1_A, 32'hDEADBEEF);
            end
            chk();
        end
        nx(); idle(5'd3, 5'd3);
        ex("array_rd3", RD0_A, 32'hDEADBEEF);
        chk();

        // Bypass then array read.
        nx(); drv(1'b1, 5'd5, 32'h12345678, 1'b0, 5'd0, 32'd0, 5'd3, 5'd5, 1'b0);
        ex("byp5_rd1", RD1_A, 32'h12345678);
        ex("byp5_rd0_other", RD0_A, 32'hDEADBEEF);
        chk();
        nx(); idle(5'd3, 5'd5);
        ex("arr5_rd1", RD1_A, 32'h12345678);
        chk();

        // Same-address collision: port 1 wins, both read ports agree.
        nx(); drv(1'b1, 5'd9, 32'h1111, 1'b1, 5'd9, 32'h2222, 5'd9, 5'd9, 1'b0);
        ex("coll_byp_rd0", RD0_A, 32'h2222);
        ex("coll_byp_rd1", RD1_A, 32'h2222);
        chk();
        nx(); idle(5'd9, 5'd9);
        ex("coll_arr_rd0", RD0_A, 32'h2222);
        ex("coll_arr_rd1", RD1_A, 32'h2222);
        chk();

        // Different addresses both commit.
        nx(); drv(1'b1, 5'd10, 32'hAAAA, 1'b1, 5'd11, 32'hBBBB, 5'd11, 5'd10, 1'b0);
        ex("dual_byp_rd0", RD0_A, 32'hBBBB);
        ex("dual_byp_rd1", RD1_A, 32'hAAAA);
        chk();
        nx(); idle(5'd10, 5'd11);
        ex("dual_arr_rd0", RD0_A, 32'hAAAA);
        ex("dual_arr_rd1", RD1_A, 32'hBBBB);
        chk();

        // Zero register on instance a; ordinary entry 0 on instance b.
        nx(); drv(1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 1'b0);
        ex("zero_byp_a", RD0_A, 32'd0);
        ex("zero_byp_b", RD0_B, 32'hFFFFFFFF);
        chk();
        nx(); idle(5'd0, 5'd0);
        ex("zero_arr_a", RD1_A, 32'd0);
        ex("zero_arr_b", RD1_B, 32'hFFFFFFFF);
        chk();
        nx(); drv(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hCAFE, 5'd0, 5'd0, 1'b0);
        ex("zero_p1_byp_a", RD0_A, 32'd0);
        ex("zero_p1_byp_b", RD0_B, 32'hCAFE);
        chk();
        nx(); idle(5'd0, 5'd0);
        ex("zero_p1_arr_a", RD0_A, 32'd0);
        ex("zero_p1_arr_b", RD0_B, 32'hCAFE);
        chk();

        // Fill 1..31 with index, read back.
        for (int i = 1; i < 32; i += 2) begin
            nx(); drv(1'b1, 5'(i), 32'(i), i < 31, 5'(i + 1), 32'(i + 1), 5'd0, 5'd0, 1'b0);
        end
        for (int i = 1; i < 32; i += 2) begin
            nx(); idle(5'(i), 5'(i + 1));
            ex("fill_rd0", RD0_A, 32'(i));
            ex("fill_rd1", RD1_A, (i < 31) ? 32'(i + 1) : 32'd0);
            chk();
        end

        // Clear pulse: the write alongside clr_i still commits and bypasses.
        nx(); drv(1'b1, 5'd7, 32'h77, 1'b0, 5'd0, 32'd0, 5'd7, 5'd8, 1'b1);
        ex("clr_cycle_busy", BUSY_A, 32'd0);
        ex("clr_cycle_byp", RD0_A, 32'h77);
        ex("clr_cycle_rd1", RD1_A, 32'd8);
        chk();
        for (int i = 0; i < 33; i++) begin
            nx(); drv(1'b1, 5'd4, 32'h44, 1'b0, 5'd0, 32'd0, 5'(i), 5'(31 - i), 1'b0);
            ex("clr_busy", BUSY_A, (i < 32) ? 32'd1 : 32'd0);
            if (i < 32) begin
                ex("clr_rd0", RD0_A, 32'd0);
                ex("clr_rd1", RD1_A, 32'd0);
            end
            chk();
        end
        for (int i = 1; i < 32; i += 2) begin
            nx(); idle(5'(i), 5'(i + 1));
            ex("post_clr_rd0", RD0_A, (i == 3) ? 32'd0 : ((i == 5) ? 32'd0 : 32'd0));
            ex("post_clr_rd1", RD1_A, (i == 3) ? 32'h44 : 32'd0);
            chk();
        end

        // Reset at sweep index 10 restarts a full sweep.
        nx(); drv(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd4, 5'd4, 1'b1);
        ex("mid_clr_busy", BUSY_A, 32'd0);
        ex("mid_clr_rd4", RD0_A, 32'h44);
        chk();
        for (int i = 0; i < 10; i++) begin
            nx(); idle(5'd4, 5'd4);
            ex("mid_sweep_busy", BUSY_A, 32'd1);
            chk();
        end
        for (int i = 0; i < 3; i++) begin
            nx(); rst_i = 1'b0;
            drv(1'b1, 5'd12, 32'h5A, 1'b0, 5'd0, 32'd0, 5'd12, 5'd4, 1'b0);
            ex("mid_rst_busy", BUSY_A, 32'd1);
            ex("mid_rst_rd", RD0_A, 32'd0);
            chk();
        end
        for (int i = 0; i < 33; i++) begin
            nx();
            if (i == 0) rst_i = 1'b1;
            idle(5'd12, 5'd4);
            ex("resweep_busy", BUSY_A, (i < 32) ? 32'd1 : 32'd0);
            ex("resweep_busy_b", BUSY_B, (i < 32) ? 32'd1 : 32'd0);
            if (i == 32) begin
                ex("resweep_rd12", RD0_A, 32'd0);
                ex("resweep_rd4", RD1_A, 32'd0);
            end
            chk();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
